// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson code decoder/checker: FSM encoding,
// index width derivation and modular successor.
package johnson_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic int idx_width(input int width);
        return $clog2(32'd2 * width);
    endfunction

    // Successor of a state index in a ring of 2*width states
    function automatic int unsigned next_index(input int unsigned idx, input int unsigned width);
        if (idx + 32'd1 >= 32'd2 * width) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code word classifier: legal flag and state index.
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] code,
    output logic             legal,
    output logic [IDX_W-1:0] index
);

    int               pop_s;
    logic [WIDTH-1:0] low_s;
    logic [WIDTH-1:0] high_s;

    // Popcount, then compare against the contiguous-ones pattern it implies
    always_comb begin
        pop_s  = 0;
        low_s  = '0;
        high_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_s = pop_s + int'(code[i]);
        end
        for (int i = 0; i < WIDTH; i++) begin
            low_s[i]  = (i < pop_s);
            high_s[i] = (i >= WIDTH - pop_s);
        end
        if (code[WIDTH-1]) begin
            legal = (code == high_s);
            index = IDX_W'(2 * WIDTH - pop_s);
        end else begin
            legal = (code == low_s);
            index = IDX_W'(pop_s);
        end
    end

endmodule

// File: rtl/johnson_decoder_checker.sv
// Johnson code receiver: decodes the phase index, tracks sequence lock and
// counts illegal/out-of-sequence events with a saturating counter.
module johnson_decoder_checker
    import johnson_pkg::*;
#(
    parameter  int WIDTH      = 4,
    parameter  int LOCK_COUNT = 3,
    parameter  int CNT_W      = 8,
    localparam int IDX_W      = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    input  logic [WIDTH-1:0] code,
    output logic [IDX_W-1:0] index,
    output logic             index_valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [CNT_W-1:0] err_count
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   exp_r, exp_s;
    logic [MATCH_W-1:0] match_r, match_s;
    logic [MATCH_W-1:0] match_inc_s;
    logic [IDX_W-1:0]   succ_s;
    logic               dec_legal_s;
    logic [IDX_W-1:0]   dec_index_s;
    logic               illegal_s, seq_err_s;
    logic [CNT_W-1:0]   err_s;

    johnson_code_decode #(.WIDTH(WIDTH)) u_decode (
        .code  (code),
        .legal (dec_legal_s),
        .index (dec_index_s)
    );

    assign succ_s      = IDX_W'(next_index(32'(dec_index_s), 32'(WIDTH)));
    assign match_inc_s = match_r + MATCH_W'(1);

    // Next-state, expected successor, match count and error event decision
    always_comb begin
        state_s   = state_r;
        exp_s     = exp_r;
        match_s   = match_r;
        illegal_s = 1'b0;
        seq_err_s = 1'b0;
        if (code_valid) begin
            illegal_s = ~dec_legal_s;
            case (state_r)
                ST_HUNT: begin
                    if (dec_legal_s) begin
                        exp_s   = succ_s;
                        match_s = MATCH_W'(1);
                        state_s = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
                    end else begin
                        state_s = ST_HUNT;
                    end
                end
                ST_VERIFY: begin
                    if (!dec_legal_s) begin
                        state_s = ST_HUNT;
                    end else if (dec_index_s == exp_r) begin
                        exp_s   = succ_s;
                        match_s = match_inc_s;
                        state_s = (match_inc_s >= MATCH_W'(LOCK_COUNT)) ? ST_LOCKED : ST_VERIFY;
                    end else begin
                        exp_s   = succ_s;
                        match_s = MATCH_W'(1);
                        state_s = ST_VERIFY;
                    end
                end
                ST_LOCKED: begin
                    if (dec_legal_s && (dec_index_s == exp_r)) begin
                        exp_s = succ_s;
                    end else begin
                        seq_err_s = 1'b1;
                        state_s   = ST_HUNT;
                    end
                end
                default: begin
                    state_s = ST_HUNT;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // One increment per error cycle, even when illegal and seq_err coincide
    always_comb begin
        err_s = err_count;
        if ((illegal_s || seq_err_s) && (err_count != CNT_MAX)) begin
            err_s = err_count + CNT_W'(1);
        end else begin
            err_s = err_count;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_HUNT;
            exp_r       <= '0;
            match_r     <= '0;
            index       <= '0;
            index_valid <= 1'b0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;
            locked      <= 1'b0;
            err_count   <= '0;
        end else begin
            state_r     <= state_s;
            exp_r       <= exp_s;
            match_r     <= match_s;
            index_valid <= code_valid && dec_legal_s;
            illegal     <= illegal_s;
            seq_err     <= seq_err_s;
            locked      <= (state_s == ST_LOCKED);
            err_count   <= err_s;
            if (code_valid && dec_legal_s) begin
                index <= dec_index_s;
            end
        end
    end

endmodule
